fp_to_fixed_pipe: RTL and testbench
===================================

Name: fp_to_fixed_pipe

Overview:
Parametrised, pipelined successor to the single-cycle float-to-fixed converter. It converts IEEE-754 single-precision inputs to sign-magnitude fixed point with configurable integer and fractional widths. Unlike the single-cycle version, it handles the full exponent range, saturates on overflow, detects NaN, infinity and denormal inputs, and uses a valid/ready handshake with backpressure. It sits between the Monte-Carlo float sources and the fixed-point accumulator datapath.

Parameters:
INT_W, 1, integer magnitude bits (1..8)
FRAC_W, 19, fractional bits (1..30); INT_W+FRAC_W <= 32

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid_i  in  1  input word valid
in_ready_o  out  1  converter accepts input this cycle
fp_i  in  32  IEEE-754 single input
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
sign_o  out  1  result sign
integer_o  out  INT_W  integer magnitude
fractional_o  out  FRAC_W  fractional magnitude
ovf_o  out  1  saturated (|x| >= 2^INT_W, or infinity)
nan_o  out  1  input was NaN
uf_o  out  1  nonzero input produced zero magnitude (denormal flush or shifted out)

Behaviour:
- Three register stages. S1: decode sign, exponent e, mantissa m, and classify. S2: barrel-shift {1,m} by u=e-127 into an (INT_W+FRAC_W+guard) window. S3: round or truncate, saturate, flag.
- Latency: 3 cycles from accepted input to out_valid_o when there is no stall.
- Stage valids v1..v3. advance = out_ready_i | ~v3. in_ready_o = advance. When advance=0, all stages hold their data and valids; nothing is lost or duplicated, and order is preserved.
- Transfer in: in_valid_i & in_ready_o. Transfer out: out_valid_o & out_ready_i. out_valid_o = v3.
- While out_valid_o=1 and out_ready_i=0, every output holds stable.
- Classification:
  - e==255, m!=0 (NaN): magnitude 0, sign_o=0, nan_o=1.
  - e==255, m==0 (infinity): magnitude all-ones, ovf_o=1, sign passed through.
  - e==0 (zero or denormal): magnitude 0, sign passed through. uf_o=1 only if m!=0.
  - u >= INT_W: magnitude all-ones, ovf_o=1.
  - u < -(FRAC_W+1): magnitude 0, uf_o=1.
- Normal path: magnitude = floor({1,m} * 2^u) truncated to FRAC_W fractional bits.
- Only one flag is set per result. Priority: nan > ovf > uf.
- Reset: v1..v3=0, out_valid_o=0, sign_o=0, integer_o=0, fractional_o=0, all flags 0, in_ready_o=1 on the first cycle after reset. Reset mid-stream discards all in-flight words.
- Simultaneous transfer in and out while full: accepted. The pipeline shifts by one stage.

Optional Feature:
ROUND_NEAREST_EN
- Defined: S3 rounds half-up on magnitude, using guard and sticky bits from S2. A carry out of the top integer bit saturates to all-ones and sets ovf_o. Latency is unchanged.
- Undefined: the result is truncated toward zero, matching the single-cycle converter.

Test Plan:
Default parameters apply below. Fractional values are 19-bit hex.
- 0x3F000000 (0.5), out_ready_i=1 -> 3 cycles later: sign 0, int 0, frac 0x40000, no flags.
- 0x3FC00000 (1.5) -> int 1, frac 0x40000. 0xBF400000 (-0.75) -> sign 1, int 0, frac 0x60000.
- 0x40000000 (2.0) -> int 1, frac 0x7FFFF, ovf_o=1. 0xFF800000 (-inf) -> sign 1, all-ones, ovf_o=1.
- 0x7FC00000 (NaN) -> sign 0, magnitude 0, nan_o=1. 0x00000001 (denormal) -> magnitude 0, uf_o=1.
- 0x3F7FFFFF:
  - ROUND_NEAREST_EN undefined -> int 0, frac 0x7FFFF.
  - ROUND_NEAREST_EN defined -> int 1, frac 0x00000, no flags.
- Stream 8 words back-to-back, hold out_ready_i low for 4 cycles mid-stream -> in_ready_o low during the stall, outputs stable, all 8 results in order. Assert rst mid-stream -> out_valid_o=0 next cycle, no stale words emitted afterwards.

Source files
------------

// File: rtl/fp_to_fixed_pipe.sv
// fp_to_fixed_pipe: 3-stage IEEE-754 single to sign-magnitude fixed-point converter with valid/ready.
// Define ROUND_NEAREST_EN for round-half-up; otherwise results truncate toward zero.
module fp_to_fixed_pipe #(
  parameter int INT_W  = 1,
  parameter int FRAC_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       fp_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              sign_o,
  output logic [INT_W-1:0]  integer_o,
  output logic [FRAC_W-1:0] fractional_o,
  output logic              ovf_o,
  output logic              nan_o,
  output logic              uf_o
);
  localparam int W  = INT_W + FRAC_W;
  localparam int XW = W + 24;
`ifdef ROUND_NEAREST_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam logic signed [9:0] UMAX = 10'(INT_W);
  localparam logic signed [9:0] UMIN = 10'(-(FRAC_W + 1));
  localparam logic signed [9:0] SOFF = 10'(FRAC_W + 1);

  logic              v1, v2, v3, advance;
  logic [7:0]        e;
  logic signed [9:0] u;
  logic              nan1, ovf1, zero1;
  logic              s1_sign, s1_nan, s1_ovf, s1_zero, s1_uf;
  logic [5:0]        s1_sh;
  logic [22:0]       s1_man;
  logic              s2_sign, s2_nan, s2_ovf, s2_zero, s2_uf;
  logic [W+G-1:0]    s2_mag, mag2;
  logic [W:0]        sum;
  logic              ovf3, uf3;
  logic [W-1:0]      mag3;

  assign advance     = out_ready_i | ~v3;
  assign in_ready_o  = advance;
  assign out_valid_o = v3;

  assign e     = fp_i[30:23];
  assign u     = $signed({2'b00, e}) - 10'sd127;
  assign nan1  = &e && |fp_i[22:0];
  assign ovf1  = !nan1 && u >= UMAX;
  assign zero1 = u < UMIN;

  // shift by u+FRAC_W+1 places the binary point one bit (the guard) below the fixed-point LSB
  assign mag2 = (W+G)'((XW'({1'b1, s1_man}) << s1_sh) >> (24 - G));

  always_comb begin
`ifdef ROUND_NEAREST_EN
    sum = {1'b0, s2_mag[W:1]} + (W+1)'(s2_mag[0]);
`else
    sum = {1'b0, s2_mag};
`endif
    ovf3 = s2_ovf || (!s2_nan && !s2_zero && sum[W]);
    mag3 = (s2_nan || s2_zero) ? '0 : ovf3 ? '1 : sum[W-1:0];
    uf3  = s2_zero ? s2_uf : (!s2_nan && !ovf3 && mag3 == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, v2, v3} <= '0;
      {s1_sign, s1_nan, s1_ovf, s1_zero, s1_uf, s1_sh, s1_man} <= '0;
      {s2_sign, s2_nan, s2_ovf, s2_zero, s2_uf, s2_mag} <= '0;
      {sign_o, integer_o, fractional_o, ovf_o, nan_o, uf_o} <= '0;
    end else if (advance) begin
      v1      <= in_valid_i;
      s1_sign <= fp_i[31] & ~nan1;
      s1_nan  <= nan1;
      s1_ovf  <= ovf1;
      s1_zero <= zero1;
      s1_uf   <= zero1 && |fp_i[30:0];
      s1_sh   <= 6'(u + SOFF);
      s1_man  <= fp_i[22:0];
      v2      <= v1;
      s2_sign <= s1_sign;
      s2_nan  <= s1_nan;
      s2_ovf  <= s1_ovf;
      s2_zero <= s1_zero;
      s2_uf   <= s1_uf;
      s2_mag  <= mag2;
      v3      <= v2;
      sign_o  <= s2_sign;
      {integer_o, fractional_o} <= mag3;
      ovf_o   <= ovf3;
      nan_o   <= s2_nan;
      uf_o    <= uf3;
    end
  end
endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// tb_fp_to_fixed_pipe: directed and randomized checks of fp_to_fixed_pipe against a real-arithmetic model.
module tb_fp_to_fixed_pipe;
  localparam int INT_W  = 1;
  localparam int FRAC_W = 19;
  localparam int W      = INT_W + FRAC_W;

  logic              clk = 0;
  logic              rst = 1;
  logic              in_valid_i = 0;
  logic              in_ready_o;
  logic [31:0]       fp_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 0;
  logic              sign_o;
  logic [INT_W-1:0]  integer_o;
  logic [FRAC_W-1:0] fractional_o;
  logic              ovf_o, nan_o, uf_o;
  logic [W+3:0]      obs;
  int                errors = 0;
  int                checks = 0;

  fp_to_fixed_pipe #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .fp_i(fp_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .sign_o(sign_o), .integer_o(integer_o),
    .fractional_o(fractional_o), .ovf_o(ovf_o), .nan_o(nan_o), .uf_o(uf_o)
  );

  always #5 clk = ~clk;
  assign obs = {sign_o, integer_o, fractional_o, ovf_o, nan_o, uf_o};

  // {sign, magnitude, ovf, nan, uf} from the real value of the float
  function automatic logic [W+3:0] model(input logic [31:0] f);
    logic [7:0]   ex;
    logic [22:0]  m;
    real          sc;
    logic [W-1:0] mag;
    ex = f[30:23];
    m  = f[22:0];
    if (ex == 8'hff) return (m != 0) ? {1'b0, {W{1'b0}}, 3'b010} : {f[31], {W{1'b1}}, 3'b100};
    if (ex == 8'h00) return {f[31], {W{1'b0}}, 2'b00, m != 0};
    sc = real'({1'b1, m}) * 2.0 ** (real'(ex) - 150.0 + real'(FRAC_W));
`ifdef ROUND_NEAREST_EN
    sc = sc + 0.5;
`endif
    sc = $floor(sc);
    if (sc >= 2.0 ** W) return {f[31], {W{1'b1}}, 3'b100};
    mag = W'(longint'(sc));
    return {f[31], mag, 2'b00, mag == 0};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int          k;
    logic [7:0]  ex;
    logic [22:0] m;
    k  = $urandom_range(0, 9);
    ex = (k <= 1) ? 8'hff : (k == 2) ? 8'h00 : (k == 3) ? 8'($urandom) :
         8'($urandom_range(127 - FRAC_W - 3, 127 + INT_W + 1));
    m  = (k == 1) ? 23'd0 : (k == 4) ? '1 : (k == 0) ? (23'($urandom) | 23'd1) : 23'($urandom);
    return {1'($urandom), ex, m};
  endfunction

  task automatic test_reset();
    rst = 1; in_valid_i = 0; out_ready_i = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || obs !== '0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b obs=%h want valid=0 obs=0", out_valid_o, obs);
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", in_ready_o);
    end
    rst = 0;
  endtask

  task automatic test_directed();
    logic [31:0]  din  [8];
    logic [W+3:0] dexp [8];
    int           k;
    din  = '{32'h3F000000, 32'h3FC00000, 32'hBF400000, 32'h40000000,
             32'hFF800000, 32'h7FC00000, 32'h00000001, 32'h3F7FFFFF};
    dexp = '{{2'b00, 19'h40000, 3'b000}, {2'b01, 19'h40000, 3'b000}, {2'b10, 19'h60000, 3'b000},
             {2'b01, 19'h7FFFF, 3'b100}, {2'b11, 19'h7FFFF, 3'b100}, {2'b00, 19'h00000, 3'b010},
`ifdef ROUND_NEAREST_EN
             {2'b00, 19'h00000, 3'b001}, {2'b01, 19'h00000, 3'b000}};
`else
             {2'b00, 19'h00000, 3'b001}, {2'b00, 19'h7FFFF, 3'b000}};
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid_i = 1; fp_i = din[i]; out_ready_i = 1;
      @(negedge clk);
      in_valid_i = 0;
      k = 1;
      while (!out_valid_o && k < 10) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (k != 3) begin
        errors++; $display("FAIL latency[%h]: got %0d want 3", din[i], k);
      end
      checks++;
      if (obs !== dexp[i]) begin
        errors++; $display("FAIL directed[%h]: got %h want %h", din[i], obs, dexp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random(input int n);
    logic [W+3:0] q[$];
    logic [W+3:0] ex, held;
    int           sent = 0, got = 0, cyc = 0;
    logic         stalled = 0;
    while (got < n && cyc < 20 * n) begin
      @(negedge clk);
      cyc++;
      in_valid_i  = sent < n && $urandom_range(0, 3) != 0;
      fp_i        = rnd_fp();
      out_ready_i = $urandom_range(0, 3) != 0;
      #1;
      checks++;
      if (in_ready_o !== (out_ready_i | ~out_valid_o)) begin
        errors++; $display("FAIL rand_ready: got %b want %b", in_ready_o, out_ready_i | ~out_valid_o);
      end
      if (stalled) begin
        checks++;
        if (out_valid_o !== 1'b1 || obs !== held) begin
          errors++; $display("FAIL rand_hold: got valid=%b obs=%h want valid=1 obs=%h", out_valid_o, obs, held);
        end
      end
      stalled = out_valid_o && !out_ready_i;
      held    = obs;
      if (in_valid_i && in_ready_o) begin
        q.push_back(model(fp_i));
        sent++;
      end
      if (out_valid_o && out_ready_i) begin
        ex = q.size() != 0 ? q.pop_front() : 'x;
        checks++;
        if (obs !== ex) begin
          errors++; $display("FAIL rand_result[%0d]: got %h want %h", got, obs, ex);
        end
        got++;
      end
    end
    in_valid_i = 0;
    checks++;
    if (got != n) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", got, n);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] q[$];
    logic [W+3:0] ex, held;
    int           sent = 0, got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      in_valid_i  = sent < 8;
      fp_i        = {1'($urandom), 8'($urandom_range(120, 128)), 23'($urandom)};
      out_ready_i = !(c >= 5 && c < 9);
      #1;
      if (c >= 5 && c < 9) begin
        checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
          errors++; $display("FAIL stall_ready: got ready=%b valid=%b want ready=0 valid=1", in_ready_o, out_valid_o);
        end
        if (c == 5) held = obs;
        else begin
          checks++;
          if (obs !== held) begin
            errors++; $display("FAIL stall_hold: got %h want %h", obs, held);
          end
        end
      end
      if (in_valid_i && in_ready_o) begin
        q.push_back(model(fp_i));
        sent++;
      end
      if (out_valid_o && out_ready_i) begin
        ex = q.size() != 0 ? q.pop_front() : 'x;
        checks++;
        if (obs !== ex) begin
          errors++; $display("FAIL b2b_result[%0d]: got %h want %h", got, obs, ex);
        end
        got++;
      end
    end
    in_valid_i = 0;
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL b2b_count: got %0d want 8", got);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid_i = 1; fp_i = 32'h3FC00000; out_ready_i = c != 3;
    end
    @(negedge clk);
    rst = 1; in_valid_i = 0; out_ready_i = 1;
    @(negedge clk);
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || obs !== '0 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL midreset: got valid=%b ready=%b obs=%h want 0 1 0", out_valid_o, in_ready_o, obs);
    end
    rst = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_o) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL midreset_stale: got %0d stale outputs want 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(300);
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
